// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution column sequencer:
//   - sequencer state encoding
//   - default image geometry and pixel width
//   - number of engine column buffers (window of 3 plus one being refilled)
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int IMG_HEIGHT_DEF = 480;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_NB         = 8;   // pixel bit width inside the engine
  localparam int NUM_COL_BUF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_CONV  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/conv_win_rotator.sv
// ---------------------------------------------------------------------------
// conv_win_rotator
// Mod-4 pointer into the engine column buffers. o_base is the leftmost buffer
// of the current 3-column window; o_fetch_sel is the one buffer outside the
// window, i.e. where the next incoming column is written.
//
// Ports
//   clk100      : clock, rising edge
//   in_reset    : synchronous active-high reset
//   i_clear     : return the window to buffer 0 (frame boundary)
//   i_advance   : slide the window one buffer to the right
//   o_base      : leftmost window buffer index
//   o_fetch_sel : buffer index to refill, (o_base + 3) mod 4
// ---------------------------------------------------------------------------
module conv_win_rotator
  import conv_pkg::*;
(
  input  logic       clk100,
  input  logic       in_reset,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [1:0] o_base,
  output logic [1:0] o_fetch_sel
);

  logic [1:0] r_base;

  // Two-bit arithmetic wraps naturally, giving mod-4 behaviour for free.
  always_ff @(posedge clk100) begin
    if (in_reset) begin
      r_base <= 2'd0;
    end else if (i_clear) begin
      r_base <= 2'd0;
    end else if (i_advance) begin
      r_base <= r_base + 2'd1;
    end
  end

  assign o_base      = r_base;
  assign o_fetch_sel = r_base + 2'(NUM_COL_BUF - 1);

endmodule

// File: rtl/conv_column_sequencer.sv
// ---------------------------------------------------------------------------
// conv_column_sequencer
// Feeds columns into a 4-buffer 3x3 convolution engine and steps the engine
// down each column. Three columns are primed, then for every output column
// the engine runs IMG_HEIGHT rows before one new column is fetched into the
// free buffer and the window slides right.
//
// Ports
//   clk100       : clock, rising edge
//   in_reset     : synchronous active-high reset (priority over everything)
//   i_start      : frame-start pulse, honoured only when idle
//   i_col_valid  : column source has a full column
//   o_col_ready  : sequencer will accept a column (PRIME/FETCH)
//   o_col_load   : column buffer write strobe (valid & ready)
//   o_col_sel    : column buffer being written
//   o_win_base   : leftmost buffer of the active 3-column window
//   i_out_ready  : downstream accepts a pixel
//   o_conv_en    : engine computes row o_row this cycle
//   o_row        : current output row
//   o_out_col    : current output column, 0..IMG_WIDTH-3
//   o_busy       : not idle
//   o_frame_done : one-cycle end-of-frame pulse
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_PRIME | loading the first three columns into buffers 0,1,2
// ST_CONV  | stepping rows of the current window while i_out_ready
// ST_FETCH | loading the next column into the free buffer
// ST_DONE  | end-of-frame pulse, back to idle
// ---------------------------------------------------------------------------
module conv_column_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF
) (
  input  logic                          clk100,
  input  logic                          in_reset,
  input  logic                          i_start,
  input  logic                          i_col_valid,
  output logic                          o_col_ready,
  output logic                          o_col_load,
  output logic [1:0]                    o_col_sel,
  output logic [1:0]                    o_win_base,
  input  logic                          i_out_ready,
  output logic                          o_conv_en,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  o_out_col,
  output logic                          o_busy,
  output logic                          o_frame_done
);

  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 3);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_prime_cnt;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;

  logic              w_xfer;
  logic              w_clr_all;
  logic              w_prime_inc;
  logic              w_row_inc;
  logic              w_row_clr;
  logic              w_col_adv;
  logic [1:0]        w_base;
  logic [1:0]        w_fetch_sel;

  assign o_col_ready = (r_state == ST_PRIME) || (r_state == ST_FETCH);
  assign w_xfer      = i_col_valid & o_col_ready;
  assign o_col_load  = w_xfer;
  assign o_busy      = (r_state != ST_IDLE);

  always_ff @(posedge clk100) begin
    if (in_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_col_sel    = 2'd0;
    o_conv_en    = 1'b0;
    o_frame_done = 1'b0;
    w_clr_all    = 1'b0;
    w_prime_inc  = 1'b0;
    w_row_inc    = 1'b0;
    w_row_clr    = 1'b0;
    w_col_adv    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_PRIME;
          w_clr_all   = 1'b1;
        end
      end
      ST_PRIME: begin
        o_col_sel = r_prime_cnt;
        if (w_xfer) begin
          w_prime_inc = 1'b1;
          if (r_prime_cnt == 2'd2) begin
            w_state_nxt = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        o_conv_en = i_out_ready;
        if (i_out_ready) begin
          if (r_row == ROW_LAST) begin
            w_row_clr   = 1'b1;
            w_state_nxt = (r_col == COL_LAST) ? ST_DONE : ST_FETCH;
          end else begin
            w_row_inc = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        o_col_sel = w_fetch_sel;
        if (w_xfer) begin
          w_col_adv   = 1'b1;
          w_state_nxt = ST_CONV;
        end
      end
      ST_DONE: begin
        o_frame_done = 1'b1;
        w_clr_all    = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Prime count only matters for three transfers; it returns to 0 after the
  // third so it is already clear for the next frame.
  always_ff @(posedge clk100) begin
    if (in_reset) begin
      r_prime_cnt <= 2'd0;
      r_row       <= '0;
      r_col       <= '0;
    end else if (w_clr_all) begin
      r_prime_cnt <= 2'd0;
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      if (w_prime_inc) begin
        r_prime_cnt <= (r_prime_cnt == 2'd2) ? 2'd0 : r_prime_cnt + 2'd1;
      end
      if (w_row_clr) begin
        r_row <= '0;
      end else if (w_row_inc) begin
        r_row <= r_row + 1'b1;
      end
      if (w_col_adv) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  conv_win_rotator u_rotator (
    .clk100      (clk100),
    .in_reset    (in_reset),
    .i_clear     (w_clr_all),
    .i_advance   (w_col_adv),
    .o_base      (w_base),
    .o_fetch_sel (w_fetch_sel)
  );

  assign o_win_base = w_base;
  assign o_row      = r_row;
  assign o_out_col  = r_col;

endmodule
